note_sequencer: RTL



---
 rtl/note_pkg.sv | 39 +++
 rtl/beat_timer.sv | 37 +++
 rtl/note_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared constants and types for the beat-synchronous note record/playback sequencer.
package note_pkg;

    localparam int RAM_DEPTH = 64;
    localparam int ADDR_W    = 6;
    localparam int LEN_W     = 7;
    localparam int NOTE_W    = 32;
    localparam int PERIOD_W  = 32;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(RAM_DEPTH);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RECORD = 2'd1,
        MODE_PLAY   = 2'd2
    } mode_t;

    // S_PLAY_END keeps PLAY mode alive for the final note_valid of a one-shot playback.
    typedef enum logic [1:0] {
        S_IDLE,
        S_RECORD,
        S_PLAY,
        S_PLAY_END
    } seq_state_t;

    localparam logic [PERIOD_W-1:0] TEMPO_PERIOD [8] = '{
        32'd75000000, 32'd50000000, 32'd37500000, 32'd30000000,
        32'd25000000, 32'd21428571, 32'd16666667, 32'd13636364
    };

    // A divided period of zero would stall the timer, so the shortest beat is one cycle.
    function automatic logic [PERIOD_W-1:0] scaled_period(input logic [2:0] idx,
                                                          input int unsigned div);
        logic [PERIOD_W-1:0] p;
        p = TEMPO_PERIOD[idx] / div;
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat timebase: counts down the tempo period while running and pulses beat at zero.
module beat_timer
    import note_pkg::*;
#(
    parameter int unsigned SIM_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic [2:0] tempo,
    output logic       beat
);

    logic [PERIOD_W-1:0] period_lut [8];
    logic [PERIOD_W-1:0] count;

    for (genvar i = 0; i < 8; i++) begin : g_period
        assign period_lut[i] = scaled_period(3'(i), SIM_DIV);
    end

    assign beat = run && (count == '0);

    // Loading zero makes the first beat land on the cycle after a start; tempo is read only at reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (beat) begin
            count <= period_lut[tempo] - PERIOD_W'(1);
        end else if (run) begin
            count <= count - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback sequencer for the 64x32 note RAM: owns beat timing, RAM address/write and length.
module note_sequencer
    import note_pkg::*;
#(
    parameter int unsigned SIM_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_record,
    input  logic              start_play,
    input  logic              stop,
    input  logic [2:0]        tempo,
    input  logic              loop_en,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [NOTE_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [NOTE_W-1:0] ram_data,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              beat,
    output logic [1:0]        mode,
    output logic [LEN_W-1:0]  rec_len,
    output logic              full,
    output logic              play_done
);

    seq_state_t        state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [LEN_W-1:0]  len_q, len_next, len_inc;
    logic              full_q, full_next;
    logic              rd_pending, rd_pending_next;
    logic [NOTE_W-1:0] note_q, note_next;
    logic              zero_done, zero_done_next;
    logic              timer_load, timer_run, beat_int, last_ptr;

    assign timer_run = (state == S_RECORD) || (state == S_PLAY);

    beat_timer #(
        .SIM_DIV (SIM_DIV)
    ) u_beat_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .run   (timer_run),
        .tempo (tempo),
        .beat  (beat_int)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            len_q      <= '0;
            full_q     <= 1'b0;
            rd_pending <= 1'b0;
            note_q     <= '0;
            zero_done  <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            len_q      <= len_next;
            full_q     <= full_next;
            rd_pending <= rd_pending_next;
            note_q     <= note_next;
            zero_done  <= zero_done_next;
        end
    end

    // stop outranks both starts and also cancels a beat's write or read in the same cycle.
    always_comb begin
        state_next      = state;
        ptr_next        = ptr;
        len_next        = len_q;
        full_next       = full_q;
        rd_pending_next = 1'b0;
        note_next       = note_q;
        zero_done_next  = 1'b0;
        timer_load      = 1'b0;
        ram_wren        = 1'b0;
        note_valid      = 1'b0;
        play_done       = zero_done;
        len_inc         = len_q + LEN_W'(1);
        last_ptr        = ({1'b0, ptr} == (len_q - LEN_W'(1)));
        mode            = MODE_IDLE;

        if (rd_pending && !stop) begin
            note_valid = 1'b1;
            note_next  = ram_q;
        end

        case (state)
            S_IDLE: begin
                if (!stop && start_record) begin
                    state_next = S_RECORD;
                    ptr_next   = '0;
                    len_next   = '0;
                    full_next  = 1'b0;
                    note_next  = '0;
                    timer_load = 1'b1;
                end else if (!stop && start_play) begin
                    if (len_q == '0) begin
                        zero_done_next = 1'b1;
                    end else begin
                        state_next = S_PLAY;
                        ptr_next   = '0;
                        timer_load = 1'b1;
                    end
                end
            end
            S_RECORD: begin
                mode = MODE_RECORD;
                if (stop) begin
                    state_next = S_IDLE;
                end else if (beat_int) begin
                    ram_wren = 1'b1;
                    ptr_next = ptr + ADDR_W'(1);
                    len_next = len_inc;
                    if (len_inc == FULL_LEN) begin
                        full_next  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_PLAY: begin
                mode = MODE_PLAY;
                if (stop) begin
                    state_next = S_IDLE;
                end else if (beat_int) begin
                    rd_pending_next = 1'b1;
                    if (!last_ptr) begin
                        ptr_next = ptr + ADDR_W'(1);
                    end else if (loop_en) begin
                        ptr_next = '0;
                    end else begin
                        state_next = S_PLAY_END;
                    end
                end
            end
            S_PLAY_END: begin
                mode       = MODE_PLAY;
                state_next = S_IDLE;
                if (!stop) begin
                    play_done = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign ram_addr = ptr;
    assign ram_data = ram_wren ? note_in : '0;
    assign note_out = note_valid ? ram_q : note_q;
    assign beat     = beat_int;
    assign rec_len  = len_q;
    assign full     = full_q;

endmodule
